uart_str_sched: RTL
===================

UART_STR_SCHED -- requirements
Module: uart_str_sched

Interface
REQ-001 Parameter STR_LEN, default 8, number of string bytes sent per transmission (legal range 1..16).
REQ-002 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 en  input  1  level; enables periodic sending, paced by the external interval counter.
REQ-005 send_req  input  1  one-cycle pulse; requests one immediate string transmission.
REQ-006 tick  input  1  one-cycle pulse from the interval counter (its update output).
REQ-007 timer_start  output  1  one-cycle pulse; starts the interval counter.
REQ-008 timer_stop  output  1  one-cycle pulse; stops the interval counter.
REQ-009 char_addr  output  4  byte index into the external combinational string ROM.
REQ-010 char_data  input  8  ROM byte at char_addr, valid in the same cycle.
REQ-011 tx_data  output  8  byte presented to the UART transmitter.
REQ-012 tx_valid  output  1  tx_data is valid; a transfer occurs on an edge where tx_valid=1 and tx_ready=1.
REQ-013 tx_ready  input  1  UART transmitter can accept a byte.
REQ-014 busy  output  1  high from the first FETCH through the last transfer of a string.
REQ-015 done  output  1  one-cycle pulse after the last byte of a string transfers.
REQ-016 overrun  output  1  one-cycle pulse when a tick is dropped because busy=1.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, ARMED, FETCH, SEND, FINISH.
REQ-018 IDLE: if en=1, go to ARMED and pulse timer_start in the next cycle; else if send_req=1, go to FETCH with index=0.
REQ-019 ARMED: if en=0, pulse timer_stop and go to IDLE; else if tick=1 or send_req=1, go to FETCH with index=0.
REQ-020 If tick and send_req are high in the same cycle, exactly one string SHALL be sent.
REQ-021 FETCH (one cycle): char_addr=index; register char_data into tx_data; go to SEND.
REQ-022 SEND: tx_valid=1 and tx_data SHALL hold stable until the transfer edge.
REQ-023 On the transfer edge, if index<STR_LEN-1, increment index and go to FETCH; else go to FINISH.
REQ-024 tx_valid SHALL be 0 for at least one cycle between bytes (the FETCH cycle).
REQ-025 FINISH (one cycle): pulse done.
REQ-026 FINISH exit: go to ARMED if en=1; else go to IDLE, pulsing timer_stop only if the string was started from ARMED.
REQ-027 Clearing en during FETCH/SEND SHALL NOT abort the string; the en=0 handling is applied at FINISH.
REQ-028 send_req while busy SHALL be ignored (not queued).
REQ-029 tick while busy SHALL be dropped, with a one-cycle overrun pulse in the next cycle.
REQ-030 tick while in IDLE SHALL be ignored without an overrun pulse.
REQ-031 index is 4-bit and SHALL never exceed STR_LEN-1; there is no wrap-around within a string.
REQ-032 char_addr SHALL equal index in all states.
REQ-033 Latency: trigger accepted at edge N → FETCH in cycle N+1 → tx_valid=1 from cycle N+2.
REQ-034 Minimum string duration with tx_ready held at 1: 2*STR_LEN+1 cycles from trigger edge to done pulse.
REQ-035 busy SHALL be high in FETCH and SEND and low in IDLE, ARMED and FINISH.
REQ-036 All pulse outputs SHALL be registered and exactly one cycle wide.

Reset
REQ-037 While rst=0: state=IDLE, index=0, tx_data=0x00, and tx_valid, busy, done, overrun, timer_start, timer_stop all 0; char_addr=0.
REQ-038 Reset asserted mid-string SHALL abort the string immediately, with no done pulse and no timer_stop pulse.
REQ-039 After rst rises, the first action SHALL be taken on the first rising clk edge, following the IDLE rules.

Verification
REQ-040 Enable and tick: en=1 from IDLE → timer_start pulse; tick with tx_ready=1 → STR_LEN=8 bytes ROM[0..7] transferred in order; done exactly 17 cycles after the tick edge.
REQ-041 Backpressure: tx_ready=0 for 5 cycles during byte 3 → tx_valid stays 1 and tx_data stays ROM[3]; no byte is lost or duplicated.
REQ-042 Collision and overrun: tick and send_req in the same cycle → one string only; tick during byte 2 → overrun pulse, no second string.
REQ-043 Disable mid-string: en=0 during byte 4 → all 8 bytes sent, then done, then timer_stop pulse, state IDLE.
REQ-044 Manual send and reset: send_req with en=0 → 8 bytes sent, done, no timer pulses; rst=0 during byte 5 → all outputs return to reset values asynchronously, no done pulse.
REQ-045 Boundary: STR_LEN=1 and STR_LEN=16 → exactly 1 and 16 transfers respectively; char_addr maximum is 0 and 15.

Source files
------------

// File: rtl/uart_str_sched.sv
// String scheduler: fetches STR_LEN bytes from an external ROM and streams them to a UART
// transmitter, either on a periodic tick from an interval counter or on an immediate request.
module uart_str_sched #(
  parameter int STR_LEN = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_send_req,
  input  logic       i_tick,
  output logic       o_timer_start,
  output logic       o_timer_stop,
  output logic [3:0] o_char_addr,
  input  logic [7:0] i_char_data,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overrun
);

  localparam logic [3:0] LP_LAST = 4'(STR_LEN - 1);

  typedef enum logic [2:0] {IDLE, ARMED, FETCH, SEND, FINISH} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_index, w_index_nxt;
  logic [7:0] r_tx_data, w_tx_data_nxt;
  logic       r_from_armed, w_from_armed_nxt;
  logic       r_timer_start, w_timer_start_nxt;
  logic       r_timer_stop, w_timer_stop_nxt;
  logic       r_done, w_done_nxt;
  logic       r_overrun, w_overrun_nxt;
  logic       w_busy;

  assign w_busy = (r_state == FETCH) || (r_state == SEND);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_index       <= 4'd0;
      r_tx_data     <= 8'h00;
      r_from_armed  <= 1'b0;
      r_timer_start <= 1'b0;
      r_timer_stop  <= 1'b0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_index       <= w_index_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_from_armed  <= w_from_armed_nxt;
      r_timer_start <= w_timer_start_nxt;
      r_timer_stop  <= w_timer_stop_nxt;
      r_done        <= w_done_nxt;
      r_overrun     <= w_overrun_nxt;
    end
  end

  // Pulse outputs are computed here as next values so they leave the block registered.
  always_comb begin
    w_state_nxt       = r_state;
    w_index_nxt       = r_index;
    w_tx_data_nxt     = r_tx_data;
    w_from_armed_nxt  = r_from_armed;
    w_timer_start_nxt = 1'b0;
    w_timer_stop_nxt  = 1'b0;
    w_done_nxt        = 1'b0;
    w_overrun_nxt     = i_tick & w_busy;

    case (r_state)
      IDLE: begin
        if (i_en) begin
          w_state_nxt       = ARMED;
          w_timer_start_nxt = 1'b1;
        end else if (i_send_req) begin
          w_state_nxt      = FETCH;
          w_index_nxt      = 4'd0;
          w_from_armed_nxt = 1'b0;
        end
      end
      ARMED: begin
        if (!i_en) begin
          w_state_nxt      = IDLE;
          w_timer_stop_nxt = 1'b1;
        end else if (i_tick || i_send_req) begin
          w_state_nxt      = FETCH;
          w_index_nxt      = 4'd0;
          w_from_armed_nxt = 1'b1;
        end
      end
      FETCH: begin
        w_tx_data_nxt = i_char_data;
        w_state_nxt   = SEND;
      end
      SEND: begin
        if (i_tx_ready) begin
          if (r_index != LP_LAST) begin
            w_index_nxt = r_index + 4'd1;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = FINISH;
            w_done_nxt  = 1'b1;
          end
        end
      end
      FINISH: begin
        // A stop is only owed to the interval counter if it was running for this string.
        if (i_en) begin
          w_state_nxt = ARMED;
        end else begin
          w_state_nxt      = IDLE;
          w_timer_stop_nxt = r_from_armed;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_char_addr   = r_index;
  assign o_tx_data     = r_tx_data;
  assign o_tx_valid    = (r_state == SEND);
  assign o_busy        = w_busy;
  assign o_done        = r_done;
  assign o_overrun     = r_overrun;
  assign o_timer_start = r_timer_start;
  assign o_timer_stop  = r_timer_stop;

endmodule
